// File: rtl/counter_74x161_n.sv
// counter_74x161_n: parametrised synchronous presettable up/down counter in
// the style of the 74x161/74x191 family, with ENP/ENT cascade enables,
// terminal count (TC) and ripple carry out (RCO).
//
// Optional feature macro: COUNTER_74X161_N_SCLR_EN
//   When defined, adds SCLR_N, a synchronous active-low clear (74x163 style).
//   It sits below CLR_N and above LOAD_N in priority.
//
// Cascade handshake: a stage advances on a rising CLK edge when ENP & ENT are
// high. RCO = TC & ENT feeds the next stage's ENT. ENP never gates RCO, so
// the carry chain is purely feed-forward and has no combinational loop.
// With RCO_REG=1, UP must be held stable for one cycle before a count edge
// that depends on RCO. A UP change with no clock edge is only seen by the
// predictor at the following edge.
module counter_74x161_n #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16,
  parameter bit              RCO_REG = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
`ifdef COUNTER_74X161_N_SCLR_EN
  input  logic             SCLR_N,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC
);

  // Highest in-range count value, MODULUS-1.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
  // A full binary modulus cannot hold an out-of-range value.
  localparam bit FULL_RANGE = (MODULUS == (64'd1 << WIDTH));

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_out_of_range;
  logic             w_count;
  logic             w_sclr;

  assign w_count        = ENP & ENT;
  assign w_out_of_range = FULL_RANGE ? 1'b0 : (r_q > MAX_Q);

`ifdef COUNTER_74X161_N_SCLR_EN
  assign w_sclr = ~SCLR_N;
`else
  assign w_sclr = 1'b0;
`endif

  // Next-state selection: sync clear, then load, then count, then hold.
  always_comb begin
    w_q_next = r_q;
    if (w_sclr) begin
      w_q_next = '0;
    end else if (!LOAD_N) begin
      w_q_next = D;
    end else if (w_count) begin
      if (UP) begin
        w_q_next = (r_q >= MAX_Q) ? '0 : r_q + WIDTH'(1);
      end else begin
        w_q_next = ((r_q == '0) || w_out_of_range) ? MAX_Q : r_q - WIDTH'(1);
      end
    end
  end

  // Counter state register; CLR_N clears asynchronously and wins over CLK.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign Q  = r_q;
  assign TC = UP ? (r_q == MAX_Q) : (r_q == '0);

  generate
    if (RCO_REG) begin : g_rco_reg
      logic r_tc_pred;
      logic w_tc_next;

      // TC of the next state under the current direction.
      assign w_tc_next = UP ? (w_q_next == MAX_Q) : (w_q_next == '0);

      // Prediction register so RCO lines up with Q reaching terminal count.
      always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          r_tc_pred <= 1'b0;
        end else begin
          r_tc_pred <= w_tc_next;
        end
      end

      assign RCO = r_tc_pred & ENT;
    end else begin : g_rco_comb
      assign RCO = TC & ENT;
    end
  endgenerate

endmodule

// File: tb/tb_counter_74x161_n.sv
// Bench for counter_74x161_n: an 8-bit modulus-200 pair (combinational and
// registered RCO), a 4-bit modulus-16 stage, and a two-stage 4-bit cascade.
// The reference is the counting rule in integer arithmetic. The cascade is
// modelled as a single 8-bit value that wraps at 256.
module tb_counter_74x161_n;

  logic clk;
  logic clr_n;
`ifdef COUNTER_74X161_N_SCLR_EN
  logic sclr_n;
`endif

  // Group A: WIDTH=8, MODULUS=200, shared by both RCO modes.
  logic       a_load_n, a_enp, a_ent, a_up;
  logic [7:0] a_d, a_q0, a_q1;
  logic       a_tc0, a_rco0, a_tc1, a_rco1;
  // Group B: WIDTH=4, MODULUS=16.
  logic       b_load_n, b_enp, b_ent, b_up;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_rco;
  // Group C: cascade of two WIDTH=4 stages.
  logic       c_load_n, c_enp, c_ent, c_up;
  logic [7:0] c_d;
  logic [3:0] c_q0, c_q1;
  logic       c_tc0, c_rco0, c_tc1, c_rco1;

  int am, bm, cm;
  int n_checks, n_pass, n_fail;

  counter_74x161_n #(.WIDTH(8), .MODULUS(200), .RCO_REG(1'b0)) u_a0 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(a_load_n), .ENP(a_enp), .ENT(a_ent),
    .UP(a_up),
`ifdef COUNTER_74X161_N_SCLR_EN
    .SCLR_N(sclr_n),
`endif
    .D(a_d), .Q(a_q0), .RCO(a_rco0), .TC(a_tc0));

  counter_74x161_n #(.WIDTH(8), .MODULUS(200), .RCO_REG(1'b1)) u_a1 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(a_load_n), .ENP(a_enp), .ENT(a_ent),
    .UP(a_up),
`ifdef COUNTER_74X161_N_SCLR_EN
    .SCLR_N(sclr_n),
`endif
    .D(a_d), .Q(a_q1), .RCO(a_rco1), .TC(a_tc1));

  counter_74x161_n #(.WIDTH(4), .MODULUS(16), .RCO_REG(1'b0)) u_b (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(b_load_n), .ENP(b_enp), .ENT(b_ent),
    .UP(b_up),
`ifdef COUNTER_74X161_N_SCLR_EN
    .SCLR_N(sclr_n),
`endif
    .D(b_d), .Q(b_q), .RCO(b_rco), .TC(b_tc));

  counter_74x161_n #(.WIDTH(4), .MODULUS(16), .RCO_REG(1'b0)) u_c0 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(c_ent),
    .UP(c_up),
`ifdef COUNTER_74X161_N_SCLR_EN
    .SCLR_N(sclr_n),
`endif
    .D(c_d[3:0]), .Q(c_q0), .RCO(c_rco0), .TC(c_tc0));

  counter_74x161_n #(.WIDTH(4), .MODULUS(16), .RCO_REG(1'b0)) u_c1 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(c_load_n), .ENP(c_enp), .ENT(c_rco0),
    .UP(c_up),
`ifdef COUNTER_74X161_N_SCLR_EN
    .SCLR_N(sclr_n),
`endif
    .D(c_d[7:4]), .Q(c_q1), .RCO(c_rco1), .TC(c_tc1));

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting rule on plain integers.
  function automatic int m_next(int q, int m, bit ld_n, int d, bit en, bit up);
    if (!ld_n) return d;
    if (!en) return q;
    if (up) return (q >= m - 1) ? 0 : q + 1;
    return (q == 0 || q >= m) ? m - 1 : q - 1;
  endfunction

  function automatic bit m_tc(int q, int m, bit up);
    return up ? (q == m - 1) : (q == 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_a(input string tag);
    chk({tag, " a0.Q"},   64'(a_q0),   64'(am));
    chk({tag, " a0.TC"},  64'(a_tc0),  64'(m_tc(am, 200, a_up)));
    chk({tag, " a0.RCO"}, 64'(a_rco0), 64'(m_tc(am, 200, a_up) & a_ent));
    chk({tag, " a1.Q"},   64'(a_q1),   64'(am));
    chk({tag, " a1.TC"},  64'(a_tc1),  64'(m_tc(am, 200, a_up)));
    chk({tag, " a1.RCO"}, 64'(a_rco1), 64'(m_tc(am, 200, a_up) & a_ent));
  endtask

  task automatic chk_b(input string tag);
    chk({tag, " b.Q"},   64'(b_q),   64'(bm));
    chk({tag, " b.TC"},  64'(b_tc),  64'(m_tc(bm, 16, b_up)));
    chk({tag, " b.RCO"}, 64'(b_rco), 64'(m_tc(bm, 16, b_up) & b_ent));
  endtask

  task automatic chk_c(input string tag);
    chk({tag, " c.Q"},   64'({c_q1, c_q0}), 64'(cm));
    chk({tag, " c.RCO"}, 64'(c_rco1),       64'(m_tc(cm, 256, c_up) & c_ent));
  endtask

  // One rising edge: advance every model from the inputs held before it,
  // then wait until just after the edge.
  task automatic tick();
    int an, bn, cn;
    an = m_next(am, 200, a_load_n, int'(a_d), a_enp & a_ent, a_up);
    bn = m_next(bm, 16, b_load_n, int'(b_d), b_enp & b_ent, b_up);
    if (!c_load_n) cn = int'(c_d);
    else if (c_enp & c_ent) cn = c_up ? (cm + 1) % 256 : (cm + 255) % 256;
    else cn = cm;
`ifdef COUNTER_74X161_N_SCLR_EN
    if (!sclr_n) begin
      an = 0; bn = 0; cn = 0;
    end
`endif
    if (!clr_n) begin
      an = 0; bn = 0; cn = 0;
    end
    @(posedge clk);
    #1;
    am = an; bm = bn; cm = cn;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    am = 0; bm = 0; cm = 0;
    clr_n = 1'b0;
`ifdef COUNTER_74X161_N_SCLR_EN
    sclr_n = 1'b1;
`endif
    a_load_n = 1'b1; a_enp = 1'b0; a_ent = 1'b0; a_up = 1'b1; a_d = '0;
    b_load_n = 1'b1; b_enp = 1'b0; b_ent = 1'b0; b_up = 1'b1; b_d = '0;
    c_load_n = 1'b1; c_enp = 1'b0; c_ent = 1'b0; c_up = 1'b1; c_d = '0;

    // Reset state.
    #2;
    chk_a("reset");
    chk_b("reset");
    chk_c("reset");

    // Release mid-cycle and count up to 57.
    @(posedge clk); #1;
    clr_n = 1'b1;
    a_enp = 1'b1; a_ent = 1'b1;
    for (int i = 0; i < 57; i++) tick();
    chk_a("count57");

    // Asynchronous clear mid-cycle, then the first edge gives 1.
    #2;
    clr_n = 1'b0;
    #1;
    am = 0;
    chk_a("async_clr");
    clr_n = 1'b1;
    tick();
    chk_a("after_clr");

    // Up wrap at modulus 200.
    a_load_n = 1'b0; a_d = 8'd198;
    tick();
    chk_a("load198");
    a_load_n = 1'b1;
    tick();
    chk_a("q199");
    chk("q199 tc", 64'(a_tc1 & a_rco1 & a_rco0), 64'd1);
    tick();
    chk_a("wrap0");

    // Down wrap and out-of-range loads.
    a_load_n = 1'b0; a_d = 8'd0; a_up = 1'b0;
    tick();
    chk_a("load0_down");
    a_load_n = 1'b1;
    tick();
    chk_a("down_wrap199");
    a_load_n = 1'b0; a_d = 8'd250; a_up = 1'b1;
    tick();
    chk_a("load250_up");
    a_load_n = 1'b1;
    tick();
    chk_a("oor_up");
    a_load_n = 1'b0; a_d = 8'd250; a_up = 1'b0;
    tick();
    chk_a("load250_down");
    a_load_n = 1'b1;
    tick();
    chk_a("oor_down");

    // Enables on the 4-bit stage.
    b_load_n = 1'b0; b_d = 4'd15;
    tick();
    b_load_n = 1'b1; b_enp = 1'b0; b_ent = 1'b1; b_up = 1'b1;
    tick();
    chk_b("hold_enp0");
    b_ent = 1'b0;
    #1;
    chk_b("ent0_comb");
    tick();
    chk_b("hold_ent0");
    b_load_n = 1'b0; b_d = 4'd5; b_enp = 1'b1; b_ent = 1'b1;
    tick();
    chk_b("load_over_en");
    b_load_n = 1'b1;

    // Cascade: 0x0F -> 0x10 up, then back down.
    c_load_n = 1'b0; c_d = 8'h0F;
    tick();
    c_load_n = 1'b1; c_enp = 1'b1; c_ent = 1'b1; c_up = 1'b1;
    #1;
    chk_c("casc_0f");
    tick();
    chk_c("casc_up");
    c_up = 1'b0;
    tick();
    chk_c("casc_down");

`ifdef COUNTER_74X161_N_SCLR_EN
    // Synchronous clear beats load and does not act before the edge.
    b_load_n = 1'b0; b_d = 4'd9; b_enp = 1'b0;
    tick();
    sclr_n = 1'b0; b_d = 4'd3;
    #1;
    chk_b("sclr_before_edge");
    tick();
    chk_b("sclr_edge");
    sclr_n = 1'b1; b_load_n = 1'b1;
    tick();
    chk_b("sclr_release");
`endif

    // Randomised traffic on all groups.
    for (int i = 0; i < 400; i++) begin
      a_load_n = ($urandom_range(0, 7) != 0);
      a_d      = 8'($urandom_range(0, 255));
      a_enp    = ($urandom_range(0, 3) != 0);
      a_ent    = ($urandom_range(0, 3) != 0);
      a_up     = ($urandom_range(0, 5) != 0) ? a_up : ~a_up;
      b_load_n = ($urandom_range(0, 7) != 0);
      b_d      = 4'($urandom_range(0, 15));
      b_enp    = 1'($urandom_range(0, 1));
      b_ent    = ($urandom_range(0, 3) != 0);
      b_up     = 1'($urandom_range(0, 1));
      c_load_n = ($urandom_range(0, 15) != 0);
      c_d      = 8'($urandom_range(0, 255));
      c_enp    = ($urandom_range(0, 3) != 0);
      c_ent    = ($urandom_range(0, 3) != 0);
      c_up     = ($urandom_range(0, 7) != 0) ? c_up : ~c_up;
`ifdef COUNTER_74X161_N_SCLR_EN
      sclr_n   = ($urandom_range(0, 31) != 0);
`endif
      tick();
      chk_a("rand");
      chk_b("rand");
      chk_c("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
